// File: rtl/chanels_pkg.sv
// Shared types and sizing helpers for the chanels scheduler slice.
// Contents: default-width sample struct, address-width and group-size helpers.
package chanels_pkg;

    localparam int unsigned SAMPLE_WIDTH = 32;

    // One (ac, ph) sample at the default word width.
    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] ac;
        logic [SAMPLE_WIDTH-1:0] ph;
    } chanel_sample_t;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int unsigned addr_width(input int unsigned chanels);
        return (chanels > 1) ? $clog2(chanels) : 1;
    endfunction

    // Samples per channel group.
    function automatic int unsigned group_size(input int unsigned stadies);
        return 32'd1 << stadies;
    endfunction

endpackage

// File: rtl/chanels_scheduler_if.sv
// Producer-side and distributor-side signals of the chanels scheduler.
// slave  : scheduler view (consumes s_vld/s_ac/s_ph, drives s_rdy and m_*).
// master : environment view (drives producers, observes s_rdy and m_*).
interface chanels_scheduler_if
    import chanels_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CHANELS = 4
);
    localparam int unsigned AW = addr_width(CHANELS);

    logic [CHANELS-1:0]            s_vld;
    logic [CHANELS-1:0]            s_rdy;
    logic [CHANELS-1:0][WIDTH-1:0] s_ac;
    logic [CHANELS-1:0][WIDTH-1:0] s_ph;
    logic                          m_vld;
    logic [AW-1:0]                 m_addres;
    logic [WIDTH-1:0]              m_ac;
    logic [WIDTH-1:0]              m_ph;
    logic                          m_last;

    modport slave (
        input  s_vld, s_ac, s_ph,
        output s_rdy, m_vld, m_addres, m_ac, m_ph, m_last
    );

    modport master (
        output s_vld, s_ac, s_ph,
        input  s_rdy, m_vld, m_addres, m_ac, m_ph, m_last
    );

endinterface

// File: rtl/chanels_rr_arbiter.sv
// Picks one requesting channel per cycle.
// Macro CHANELS_SCHEDULER_RR_EN: defined -> round-robin from ptr,
// undefined -> fixed priority (lowest index wins, no ptr register).
// Ports: clk, rst (sync, active-high), req (per-channel request),
//        grant_c (one-hot), grant_idx_c (encoded), grant_any_c.
module chanels_rr_arbiter
    import chanels_pkg::*;
#(
    parameter int unsigned CHANELS = 4,
    parameter int unsigned AW      = addr_width(CHANELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CHANELS-1:0] req,
    output logic [CHANELS-1:0] grant_c,
    output logic [AW-1:0]      grant_idx_c,
    output logic               grant_any_c
);

    assign grant_any_c = |req;

`ifdef CHANELS_SCHEDULER_RR_EN
    logic [AW-1:0] ptr;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int unsigned j;
        j           = 0;
        grant_c     = '0;
        grant_idx_c = '0;
        for (int unsigned i = CHANELS; i > 0; i--) begin
            j = (32'(ptr) + i - 1) % CHANELS;
            if (req[AW'(j)]) begin
                grant_c           = '0;
                grant_c[AW'(j)]   = 1'b1;
                grant_idx_c       = AW'(j);
            end
        end
    end

    // Pointer moves past the winner; idle cycles leave it in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any_c) begin
            ptr <= (grant_idx_c == AW'(CHANELS - 1)) ? '0 : grant_idx_c + AW'(1);
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Fixed priority: lowest index wins.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        for (int unsigned i = CHANELS; i > 0; i--) begin
            if (req[AW'(i - 1)]) begin
                grant_c                = '0;
                grant_c[AW'(i - 1)]    = 1'b1;
                grant_idx_c            = AW'(i - 1);
            end
        end
    end
`endif

endmodule

// File: rtl/chanels_scheduler.sv
// Serialises samples from CHANELS producers onto the single-port distributor
// input, one per clock, and flags the last sample of each per-channel group.
// Macro CHANELS_SCHEDULER_RR_EN selects round-robin (defined) or fixed priority.
// Ports: clk, rst (sync, active-high), bus (chanels_scheduler_if.slave):
//        s_vld/s_rdy/s_ac/s_ph per producer, m_vld/m_addres/m_ac/m_ph/m_last out.
module chanels_scheduler
    import chanels_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CHANELS = 4,
    parameter int unsigned STADIES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    chanels_scheduler_if.slave   bus
);

    localparam int unsigned AW    = addr_width(CHANELS);
    localparam int unsigned GROUP = group_size(STADIES);

    typedef struct packed {
        logic [WIDTH-1:0] ac;
        logic [WIDTH-1:0] ph;
    } sample_t;

    sample_t [CHANELS-1:0]              hold;
    logic    [CHANELS-1:0]              hold_vld;
    logic    [CHANELS-1:0][STADIES-1:0] cnt;

    logic [CHANELS-1:0] grant_c;
    logic [CHANELS-1:0] accept_c;
    logic [AW-1:0]      grant_idx_c;
    logic               grant_any_c;

    logic          m_vld;
    logic [AW-1:0] m_addres;
    sample_t       m_sample;
    logic          m_last;

    chanels_rr_arbiter #(
        .CHANELS (CHANELS),
        .AW      (AW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (hold_vld),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c),
        .grant_any_c (grant_any_c)
    );

    // A buffer being drained this cycle can take a new sample at the same edge.
    assign bus.s_rdy = rst ? '0 : (~hold_vld | grant_c);
    assign accept_c  = bus.s_vld & bus.s_rdy;

    // Holding buffers, group counters and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld <= '0;
            hold     <= '0;
            cnt      <= '0;
            m_vld    <= 1'b0;
            m_addres <= '0;
            m_sample <= '0;
            m_last   <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANELS; c++) begin
                if (accept_c[c]) begin
                    hold_vld[c] <= 1'b1;
                    hold[c].ac  <= bus.s_ac[c];
                    hold[c].ph  <= bus.s_ph[c];
                end else if (grant_c[c]) begin
                    hold_vld[c] <= 1'b0;
                end
            end

            m_vld  <= grant_any_c;
            m_last <= 1'b0;
            if (grant_any_c) begin
                m_addres         <= grant_idx_c;
                m_sample         <= hold[grant_idx_c];
                m_last           <= (cnt[grant_idx_c] == STADIES'(GROUP - 1));
                cnt[grant_idx_c] <= cnt[grant_idx_c] + STADIES'(1);
            end
        end
    end

    assign bus.m_vld    = m_vld;
    assign bus.m_addres = m_addres;
    assign bus.m_ac     = m_sample.ac;
    assign bus.m_ph     = m_sample.ph;
    assign bus.m_last   = m_last;

endmodule

// File: tb/tb_chanels_scheduler.sv
// Self-checking bench for chanels_scheduler (CHANELS=4, STADIES=1, WIDTH=32).
// Directed scenarios plus a randomized run checked against a queue-based model.
// Arbitration-specific scenarios follow CHANELS_SCHEDULER_RR_EN.
module tb_chanels_scheduler;
    import chanels_pkg::*;

    localparam int unsigned C  = 4;
    localparam int unsigned W  = 32;
    localparam int unsigned S  = 1;
    localparam int unsigned GS = 1 << S;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chanels_scheduler_if #(.WIDTH(W), .CHANELS(C)) bus ();

    chanels_scheduler #(
        .WIDTH   (W),
        .CHANELS (C),
        .STADIES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    // Model: each channel's accepted-but-not-emitted samples, and emitted counts.
    chanel_sample_t q[C][$];
    int unsigned    em_cnt[C];
`ifdef CHANELS_SCHEDULER_RR_EN
    int unsigned    ptr_m;
`endif

    logic [C-1:0] exp_rdy, obs_rdy;
    logic         exp_vld, obs_vld, exp_last, obs_last;
    logic [1:0]   exp_addr, obs_addr;
    logic [W-1:0] exp_ac, obs_ac, exp_ph, obs_ph;

    // Channel that should win this cycle, or -1.
    function automatic int model_pick();
        for (int unsigned i = 0; i < C; i++) begin
`ifdef CHANELS_SCHEDULER_RR_EN
            int unsigned j = (ptr_m + i) % C;
`else
            int unsigned j = i;
`endif
            if (q[j].size() != 0) return int'(j);
        end
        return -1;
    endfunction

    // One clock: drive inputs, sample s_rdy before the edge, outputs after; advance model.
    task automatic drive_cycle(input logic r, input logic [C-1:0] v,
                               input logic [C-1:0][W-1:0] ac,
                               input logic [C-1:0][W-1:0] ph);
        int g;
        chanel_sample_t smp;
        @(negedge clk);
        rst        = r;
        bus.s_vld  = v;
        bus.s_ac   = ac;
        bus.s_ph   = ph;
        #1;
        obs_rdy = bus.s_rdy;
        g       = model_pick();
        exp_rdy = '0;
        for (int c = 0; c < C; c++) exp_rdy[c] = !r && (q[c].size() == 0 || g == c);
        @(posedge clk);
        #1;
        if (r) begin
            for (int c = 0; c < C; c++) begin
                q[c].delete();
                em_cnt[c] = 0;
            end
`ifdef CHANELS_SCHEDULER_RR_EN
            ptr_m = 0;
`endif
            exp_vld  = 1'b0;
            exp_last = 1'b0;
            exp_addr = '0;
            exp_ac   = '0;
            exp_ph   = '0;
        end else begin
            exp_vld  = 1'b0;
            exp_last = 1'b0;
            if (g >= 0) begin
                smp      = q[g].pop_front();
                exp_vld  = 1'b1;
                exp_addr = 2'(g);
                exp_ac   = smp.ac;
                exp_ph   = smp.ph;
                exp_last = ((em_cnt[g] % GS) == GS - 1);
                em_cnt[g]++;
`ifdef CHANELS_SCHEDULER_RR_EN
                ptr_m = (int'(g) + 1) % C;
`endif
            end
            for (int c = 0; c < C; c++)
                if (v[c] && exp_rdy[c]) q[c].push_back('{ac: ac[c], ph: ph[c]});
        end
        obs_vld  = bus.m_vld;
        obs_addr = bus.m_addres;
        obs_ac   = bus.m_ac;
        obs_ph   = bus.m_ph;
        obs_last = bus.m_last;
    endtask

    task automatic test_reset();
        logic [C-1:0][W-1:0] d;
        for (int k = 0; k < C; k++) d[k] = 32'(100 + k);
        for (int n = 0; n < 3; n++) begin
            drive_cycle(1'b1, 4'b1111, d, d);
            tests_run++;
            if (obs_rdy !== 4'b0000) begin tests_failed++; $display("FAIL reset_rdy: got %b want 0000", obs_rdy); end
            tests_run++;
            if (obs_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_vld: got %b want 0", obs_vld); end
        end
        for (int n = 0; n < 4; n++) begin
            drive_cycle(1'b0, 4'b0000, d, d);
            if (n == 0) begin
                tests_run++;
                if (obs_rdy !== 4'b1111) begin tests_failed++; $display("FAIL release_rdy: got %b want 1111", obs_rdy); end
            end
            tests_run++;
            if (obs_vld !== 1'b0) begin tests_failed++; $display("FAIL release_vld cycle %0d: got %b want 0", n, obs_vld); end
        end
    endtask

    task automatic test_single();
        logic [C-1:0][W-1:0] a, p;
        logic        ev [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] eac[5] = '{32'd0, 32'd5, 32'd6, 32'd0, 32'd0};
        logic [W-1:0] eph[5] = '{32'd0, 32'd7, 32'd8, 32'd0, 32'd0};
        logic        el [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        a = '0; p = '0;
        drive_cycle(1'b1, 4'b0000, a, p);
        for (int n = 0; n < 5; n++) begin
            a[2] = (n == 0) ? 32'd5 : 32'd6;
            p[2] = (n == 0) ? 32'd7 : 32'd8;
            drive_cycle(1'b0, (n < 2) ? 4'b0100 : 4'b0000, a, p);
            tests_run++;
            if (obs_vld !== ev[n]) begin tests_failed++; $display("FAIL single_vld cycle %0d: got %b want %b", n, obs_vld, ev[n]); end
            if (ev[n]) begin
                tests_run++;
                if (obs_addr !== 2'd2 || obs_ac !== eac[n] || obs_ph !== eph[n] || obs_last !== el[n]) begin
                    tests_failed++;
                    $display("FAIL single_data cycle %0d: got addr=%0d ac=%0d ph=%0d last=%b want addr=2 ac=%0d ph=%0d last=%b",
                             n, obs_addr, obs_ac, obs_ph, obs_last, eac[n], eph[n], el[n]);
                end
            end
        end
    endtask

`ifdef CHANELS_SCHEDULER_RR_EN
    task automatic test_round_robin();
        logic [C-1:0][W-1:0] a, p;
        a = '0; p = '0;
        drive_cycle(1'b1, 4'b0000, a, p);
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < C; k++) begin a[k] = $urandom; p[k] = $urandom; end
            drive_cycle(1'b0, 4'b1111, a, p);
            if (n >= 1 && n <= 8) begin
                tests_run++;
                if (obs_vld !== 1'b1 || obs_addr !== 2'((n - 1) % 4) || obs_last !== 1'(((n - 1) / 4) == 1)) begin
                    tests_failed++;
                    $display("FAIL rr_seq cycle %0d: got vld=%b addr=%0d last=%b want vld=1 addr=%0d last=%b",
                             n, obs_vld, obs_addr, obs_last, (n - 1) % 4, ((n - 1) / 4) == 1);
                end
                tests_run++;
                if (obs_ac !== exp_ac || obs_ph !== exp_ph) begin
                    tests_failed++;
                    $display("FAIL rr_data cycle %0d: got ac=%h ph=%h want ac=%h ph=%h", n, obs_ac, obs_ph, exp_ac, exp_ph);
                end
            end
        end
    endtask
`else
    task automatic test_fixed_priority();
        logic [C-1:0][W-1:0] a, p;
        a = '0; p = '0;
        drive_cycle(1'b1, 4'b0000, a, p);
        for (int n = 0; n < 11; n++) begin
            a[0] = 32'(n); p[0] = 32'(n + 50);
            a[3] = 32'd300; p[3] = 32'd301;
            drive_cycle(1'b0, (n < 8) ? 4'b1001 : 4'b0000, a, p);
            if (n < 8) begin
                tests_run++;
                if (obs_rdy[3] !== (n == 0)) begin tests_failed++; $display("FAIL fixed_rdy3 cycle %0d: got %b want %b", n, obs_rdy[3], n == 0); end
            end
            if (n >= 1 && n <= 8) begin
                tests_run++;
                if (obs_vld !== 1'b1 || obs_addr !== 2'd0 || obs_ac !== 32'(n - 1)) begin
                    tests_failed++;
                    $display("FAIL fixed_ch0 cycle %0d: got vld=%b addr=%0d ac=%0d want vld=1 addr=0 ac=%0d", n, obs_vld, obs_addr, obs_ac, n - 1);
                end
            end
            if (n == 9) begin
                tests_run++;
                if (obs_vld !== 1'b1 || obs_addr !== 2'd3 || obs_ac !== 32'd300 || obs_ph !== 32'd301) begin
                    tests_failed++;
                    $display("FAIL fixed_ch3: got vld=%b addr=%0d ac=%0d ph=%0d want vld=1 addr=3 ac=300 ph=301", obs_vld, obs_addr, obs_ac, obs_ph);
                end
            end
            if (n == 10) begin
                tests_run++;
                if (obs_vld !== 1'b0) begin tests_failed++; $display("FAIL fixed_idle: got vld=%b want 0", obs_vld); end
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [C-1:0][W-1:0] a, p;
        logic [C-1:0] v;
        int idx;
        bit saw_block;
        logic [W-1:0] got[$];
        a = '0; p = '0; idx = 0; saw_block = 1'b0;
        for (int k = 0; k < C; k++) begin a[k] = 32'(200 + k); p[k] = 32'(400 + k); end
        drive_cycle(1'b1, 4'b0000, a, p);
        for (int n = 0; n < 40; n++) begin
`ifdef CHANELS_SCHEDULER_RR_EN
            v[0] = 1'b1;
`else
            v[0] = (n < 4);
`endif
            v[1] = (idx < 3);
            v[2] = 1'b1;
            v[3] = 1'b1;
            a[1] = 32'(10 + idx);
            drive_cycle(1'b0, v, a, p);
            if (v[1] && !obs_rdy[1]) saw_block = 1'b1;
            if (v[1] && obs_rdy[1]) idx++;
            if (obs_vld && obs_addr == 2'd1) got.push_back(obs_ac);
        end
        tests_run++;
        if (saw_block !== 1'b1) begin tests_failed++; $display("FAIL bp_block: got %b want 1", saw_block); end
        tests_run++;
        if (got.size() != 3) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (got[i] !== 32'(10 + i)) begin tests_failed++; $display("FAIL bp_order %0d: got %0d want %0d", i, got[i], 10 + i); end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [C-1:0][W-1:0] a, p;
        logic         sr [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [C-1:0] sv [8] = '{4'b0001, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
        logic [W-1:0] sa [8] = '{32'hA0, 32'hA1, 32'hA2, 32'h0, 32'hB0, 32'h0, 32'hC0, 32'h0};
        logic         ev [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] ea [8] = '{32'h0, 32'hA0, 32'h0, 32'h0, 32'h0, 32'hB0, 32'h0, 32'hC0};
        logic         el [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        a = '0; p = '0;
        drive_cycle(1'b1, 4'b0000, a, p);
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < C; k++) begin a[k] = sa[n] + 32'(k); p[k] = 32'(n); end
            drive_cycle(sr[n], sv[n], a, p);
            tests_run++;
            if (obs_vld !== ev[n]) begin tests_failed++; $display("FAIL midrst_vld cycle %0d: got %b want %b", n, obs_vld, ev[n]); end
            if (ev[n]) begin
                tests_run++;
                if (obs_addr !== 2'd0 || obs_ac !== ea[n] || obs_last !== el[n]) begin
                    tests_failed++;
                    $display("FAIL midrst_data cycle %0d: got addr=%0d ac=%h last=%b want addr=0 ac=%h last=%b",
                             n, obs_addr, obs_ac, obs_last, ea[n], el[n]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [C-1:0][W-1:0] a, p;
        logic [C-1:0] v;
        logic r;
        a = '0; p = '0;
        drive_cycle(1'b1, 4'b0000, a, p);
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 149) == 0);
            v = (n % 1000 < 500) ? 4'($urandom) : 4'($urandom | $urandom);
            for (int k = 0; k < C; k++) begin a[k] = $urandom; p[k] = $urandom; end
            drive_cycle(r, v, a, p);
            tests_run++;
            if (obs_rdy !== exp_rdy) begin tests_failed++; $display("FAIL rand_rdy cycle %0d: got %b want %b", n, obs_rdy, exp_rdy); end
            tests_run++;
            if (obs_vld !== exp_vld || obs_addr !== exp_addr || obs_last !== exp_last) begin
                tests_failed++;
                $display("FAIL rand_ctl cycle %0d: got vld=%b addr=%0d last=%b want vld=%b addr=%0d last=%b",
                         n, obs_vld, obs_addr, obs_last, exp_vld, exp_addr, exp_last);
            end
            tests_run++;
            if (obs_ac !== exp_ac || obs_ph !== exp_ph) begin
                tests_failed++;
                $display("FAIL rand_data cycle %0d: got ac=%h ph=%h want ac=%h ph=%h", n, obs_ac, obs_ph, exp_ac, exp_ph);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.s_vld = '0;
        bus.s_ac  = '0;
        bus.s_ph  = '0;
        test_reset();
        test_single();
`ifdef CHANELS_SCHEDULER_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/chanels_scheduler.md
# chanels_scheduler

Front-end scheduler for `chanels_distributor`. Collects (ac, ph) samples from `CHANELS` independent producers, each with a valid/ready handshake, and serialises them onto the distributor's single-port input (`i_vld`/`i_addres`/`i_ac`/`i_ph`) at a maximum of one sample per clock. It also tracks per-channel group position, so that each group of `2^STADIES` samples is flagged.

## Interface
- `WIDTH`, 32, width of ac and ph words.
- `CHANELS`, 4, number of producers; must be ≥2, need not be a power of 2.
- `STADIES`, 1, log2 of samples per channel group; must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_vld`  in  CHANELS  per-channel sample valid.
- `s_rdy`  out  CHANELS  per-channel ready.
- `s_ac`  in  CHANELS×WIDTH  per-channel ac word.
- `s_ph`  in  CHANELS×WIDTH  per-channel ph word.
- `m_vld`  out  1  to distributor `i_vld`.
- `m_addres`  out  $clog2(CHANELS)  to distributor `i_addres`.
- `m_ac`  out  WIDTH  to distributor `i_ac`.
- `m_ph`  out  WIDTH  to distributor `i_ph`.
- `m_last`  out  1  high with the final sample (index `2^STADIES-1`) of a channel's group.

## Operation
**Holding buffers**
- Each channel has a one-entry holding buffer: `hold_vld`, `hold_ac`, `hold_ph`.
- `s_rdy[c] = !rst && (!hold_vld[c] || grant[c])`. This is combinational. Refill in the same cycle as a drain is allowed.
- A sample is accepted when `s_vld[c] && s_rdy[c]`. It is captured into the buffer at the edge.

**Arbitration**
- Each cycle, the arbiter picks exactly one channel among those with `hold_vld` set, if any.
- Round-robin: search starts at `ptr`. After a grant to channel g, `ptr` becomes g+1, wrapping from `CHANELS-1` to 0. With no requests, `ptr` is unchanged.

**Output register**
- On a grant, at the next edge: `m_vld=1`, `m_addres=g`, `m_ac/m_ph` take the buffer contents.
- The granted buffer is cleared, unless it is refilled in that same cycle.
- Otherwise `m_vld=0`. `m_addres/m_ac/m_ph` hold their last value.

**Group counter**
- Per-channel counter `cnt[c]`, `STADIES` bits wide, increments on each grant of c.
- `m_last = (cnt[g] == 2^STADIES-1)`, registered with the output. The counter then wraps to 0.

**Backpressure and ordering**
- The downstream has no backpressure. Only `s_rdy` throttles producers.
- No sample is dropped or duplicated. Per-channel order is preserved.

**Reset**
- While `rst` is high at an edge: all `hold_vld`=0, all `cnt`=0, `ptr`=0, `m_vld`=0, `m_last`=0, `m_addres`=0, `m_ac`=0, `m_ph`=0. `s_rdy` is forced to 0.
- A sample presented during reset is discarded.
- Reset mid-operation abandons buffered samples and partial groups. The first sample after reset starts at group index 0.

## Timing
- Latency: a sample accepted at edge N appears on `m_*` after edge N+1 when uncontended. The minimum is 2 edges, from `s_vld` asserted to `m_vld` seen.
- Throughput: one output per cycle in aggregate. With k active channels under round-robin, each channel sustains 1/k.
- A continuously valid producer whose buffer is granted every cycle sees `s_rdy` held high.
- `s_rdy` reflects state plus the current-cycle grant. There is no combinational path from `s_vld` to `s_rdy`.
- The first cycle after `rst` deasserts: `s_rdy` = all ones, `m_vld` = 0.

## Configuration
- `CHANELS_SCHEDULER_RR_EN`
  - Defined: round-robin arbitration with the `ptr` register, as above.
  - Undefined: fixed priority, where the lowest-index channel with `hold_vld` wins. The `ptr` register is not built. A continuously valid low-index channel may starve higher indices; this is accepted behaviour in this mode.

## Structure
- Shared package `chanels_pkg`, holding:
  - `chanel_sample_t` (ac, ph structure, `WIDTH`-parameterised via the module).
  - Address-width helper function for `$clog2(CHANELS)`.
  - The `STADIES` group-size constant helper.
- One sub-module, `chanels_rr_arbiter`, containing:
  - request vector in, one-hot grant plus encoded index out;
  - the `ptr` register;
  - the macro-selected fixed/round-robin logic.
- `chanels_scheduler` holds the buffers, counters and output register.

## Test plan
All scenarios use `CHANELS=4`, `STADIES=1`, `WIDTH=32`.
1. Reset: `rst` high for 3 cycles with `s_vld=4'b1111` -> `m_vld=0` and `s_rdy=0` throughout. After release, `s_rdy=4'b1111` and no output appears from the discarded samples.
2. Single channel: ch2 presents ac=5, ph=7, then ac=6, ph=8 on consecutive cycles ->
   - two `m_vld` pulses, starting 2 edges after the first `s_vld`;
   - `m_addres=2`;
   - values in order;
   - `m_last` = 0 then 1.
3. Round-robin (macro defined): all four channels valid continuously ->
   - `m_addres` sequence 0,1,2,3,0,1,2,3 with `m_vld` high every cycle;
   - `m_last` high on the second pass for every channel.
4. Fixed priority (macro undefined): ch0 and ch3 continuously valid -> `m_addres=0` every cycle; `s_rdy[3]` stays 0 after the first accept; ch3 is emitted only when ch0 drops `s_vld`.
5. Backpressure: ch0–ch3 all hold valid, ch1 streams ac=10,11,12 -> `s_rdy[1]` deasserts while its buffer waits for a grant; all three values appear on `m_ac` in order with `m_addres=1`, none lost or duplicated.
6. Mid-operation reset: `rst` pulsed for one cycle after one ch0 sample has been emitted (`cnt[0]=1`) and with buffers full -> buffered samples are dropped; the next ch0 sample gives `m_last=0`, and the one after gives `m_last=1`.
